// File: rtl/display_scan_ctrl.sv
// Five-digit 7-segment scan controller with leading-zero blanking.
// New values are double-buffered and committed only at a frame boundary.
module display_scan_ctrl #(
    parameter int PRESCALE = 50000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [19:0] value,
    input  logic        load,
    output logic [4:0]  an,
    output logic [6:0]  seg,
    output logic        pending,
    output logic        frame_done
);

    localparam int PC_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

    logic [PC_W-1:0] pc;
    logic [2:0]      idx;
    logic [19:0]     buffer;
    logic [19:0]     active;

    logic            tick;
    logic            boundary;
    logic [3:0]      nibble;
    logic            blank;
    logic [6:0]      seg_next;
    logic [4:0]      an_next;

    // NOTE: every signal gets a default before the case statements so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        tick     = (pc == PC_W'(PRESCALE - 1));
        boundary = tick && (idx == 3'd4);
        nibble   = 4'h0;
        blank    = 1'b0;
        seg_next = 7'h7F;
        an_next  = ~(5'b00001 << idx);

        // A digit is blanked only when it and all higher digits are zero.
        case (idx)
            3'd0: nibble = active[3:0];
            3'd1: begin nibble = active[7:4];   blank = (active[19:4]  == 16'h0); end
            3'd2: begin nibble = active[11:8];  blank = (active[19:8]  == 12'h0); end
            3'd3: begin nibble = active[15:12]; blank = (active[19:12] == 8'h0);  end
            3'd4: begin nibble = active[19:16]; blank = (active[19:16] == 4'h0);  end
            default: begin nibble = 4'h0; blank = 1'b1; end
        endcase

        case (nibble)
            4'h0: seg_next = 7'h40;
            4'h1: seg_next = 7'h79;
            4'h2: seg_next = 7'h24;
            4'h3: seg_next = 7'h30;
            4'h4: seg_next = 7'h19;
            4'h5: seg_next = 7'h12;
            4'h6: seg_next = 7'h02;
            4'h7: seg_next = 7'h78;
            4'h8: seg_next = 7'h00;
            4'h9: seg_next = 7'h10;
            4'hF: seg_next = 7'h3F;
            default: seg_next = 7'h7F;
        endcase

        if (blank) begin
            seg_next = 7'h7F;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // sample the pre-edge values of one another, as the hardware does.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc         <= '0;
            idx        <= 3'd0;
            buffer     <= 20'h0;
            active     <= 20'h0;
            pending    <= 1'b0;
            frame_done <= 1'b0;
            an         <= 5'b11111;
            seg        <= 7'h7F;
        end else begin
            pc         <= tick ? '0 : pc + 1'b1;
            if (tick) begin
                idx <= (idx == 3'd4) ? 3'd0 : idx + 3'd1;
            end
            frame_done <= boundary;
            an         <= an_next;
            seg        <= seg_next;

            // A load landing on the boundary bypasses the buffer entirely.
            if (boundary) begin
                pending <= 1'b0;
                if (load) begin
                    active <= value;
                end else if (pending) begin
                    active <= buffer;
                end
            end else if (load) begin
                buffer  <= value;
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Randomized and directed bench for display_scan_ctrl against a cycle-count
// based reference model of the scan, buffering and blanking rules.
module tb_display_scan_ctrl;

    localparam int P     = 4;
    localparam int FRAME = 5 * P;

    logic        clock;
    logic        reset;
    logic [19:0] value;
    logic        load;
    logic [4:0]  an;
    logic [6:0]  seg;
    logic        pending;
    logic        frame_done;

    int total  = 0;
    int passed = 0;

    // Reference model: time since reset, displayed value, buffered value.
    int          m_cnt;
    logic [19:0] m_act;
    logic [19:0] m_buf;
    logic        m_pend;
    logic [13:0] exp_out;

    display_scan_ctrl #(.PRESCALE(P)) dut (
        .clock      (clock),
        .reset      (reset),
        .value      (value),
        .load       (load),
        .an         (an),
        .seg        (seg),
        .pending    (pending),
        .frame_done (frame_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [6:0] model_seg(input logic [19:0] a, input int k);
        int av;
        int d;
        av = int'(a);
        d  = (av >> (4 * k)) % 16;
        if (k > 0 && (av >> (4 * k)) == 0) return 7'h7F;
        case (d)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  9: return 7'h10;  15: return 7'h3F;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [19:0] rand_value();
        int v;
        int n;
        v = 0;
        for (int k = 0; k < 5; k++) begin
            n = $urandom_range(0, 15);
            if ($urandom_range(0, 2) == 0) n = 0;
            v = v | (n << (4 * k));
        end
        return 20'(v);
    endfunction

    // Applies one cycle of inputs, advances the model, returns #1 after the edge.
    task automatic cycle(input logic ld, input logic [19:0] v, input logic rst);
        int  k;
        bit  bnd;
        load  = ld;
        value = v;
        reset = rst;
        @(posedge clock);
        if (rst) begin
            m_cnt   = 0;
            m_act   = 20'h0;
            m_buf   = 20'h0;
            m_pend  = 1'b0;
            exp_out = {5'b11111, 7'h7F, 1'b0, 1'b0};
        end else begin
            k   = (m_cnt / P) % 5;
            bnd = (m_cnt % FRAME) == FRAME - 1;
            exp_out[13:9] = ~(5'b00001 << k);
            exp_out[8:2]  = model_seg(m_act, k);
            exp_out[0]    = bnd;
            if (bnd) begin
                if (ld) m_act = v;
                else if (m_pend) m_act = m_buf;
                m_pend = 1'b0;
            end else if (ld) begin
                m_buf  = v;
                m_pend = 1'b1;
            end
            exp_out[1] = m_pend;
            m_cnt++;
        end
        #1;
    endtask

    // Idles until a frame_done pulse, then records the segments of each digit.
    task automatic capture_frame(output logic [34:0] got, output bit seen);
        got  = '1;
        seen = 1'b0;
        for (int i = 0; i < 2 * FRAME && !seen; i++) begin
            cycle(1'b0, 20'h0, 1'b0);
            if (frame_done === 1'b1) seen = 1'b1;
        end
        if (seen) begin
            for (int i = 0; i < FRAME; i++) begin
                cycle(1'b0, 20'h0, 1'b0);
                for (int k = 0; k < 5; k++)
                    if (an === ~(5'b00001 << k)) got[7*k +: 7] = seg;
            end
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, 20'h0, 1'b1);
            total++;
            if ({an, seg, pending, frame_done} !== exp_out)
                $display("FAIL reset_state got=%h exp=%h", {an, seg, pending, frame_done}, exp_out);
            else passed++;
        end
        cycle(1'b0, 20'h0, 1'b0);
        total++;
        if (an !== 5'b11110 || seg !== 7'h40 || pending !== 1'b0)
            $display("FAIL first_cycle an=%b seg=%h pend=%b exp an=11110 seg=40 pend=0", an, seg, pending);
        else passed++;
    endtask

    task automatic test_idle_scan();
        int fd_count = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            cycle(1'b0, 20'h0, 1'b0);
            if (frame_done === 1'b1) fd_count++;
            total++;
            if ({an, seg, pending, frame_done} !== exp_out)
                $display("FAIL idle_scan cyc=%0d got=%h exp=%h", i, {an, seg, pending, frame_done}, exp_out);
            else passed++;
        end
        total++;
        if (fd_count !== 2) $display("FAIL idle_frame_done_count got=%0d exp=2", fd_count);
        else passed++;
    endtask

    task automatic test_load_mid_frame();
        logic [34:0] got;
        bit          seen;
        for (int i = 0; i < FRAME && (m_cnt % FRAME) != 7; i++) cycle(1'b0, 20'h0, 1'b0);
        cycle(1'b1, 20'h00F42, 1'b0);
        total++;
        if (pending !== 1'b1) $display("FAIL mid_load_pending got=%b exp=1", pending);
        else passed++;
        capture_frame(got, seen);
        total++;
        if (!seen || got !== {7'h7F, 7'h7F, 7'h3F, 7'h19, 7'h24} || pending !== 1'b0)
            $display("FAIL mid_load_digits seen=%b got=%h exp=%h pend=%b", seen, got,
                     {7'h7F, 7'h7F, 7'h3F, 7'h19, 7'h24}, pending);
        else passed++;
    endtask

    task automatic test_overwrite();
        logic [34:0] got;
        bit          seen;
        for (int i = 0; i < FRAME && (m_cnt % FRAME) != 2; i++) cycle(1'b0, 20'h0, 1'b0);
        cycle(1'b1, 20'h00012, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(i == 3, 20'h00034, 1'b0);
            total++;
            if ({an, seg, pending, frame_done} !== exp_out)
                $display("FAIL overwrite cyc=%0d got=%h exp=%h", i, {an, seg, pending, frame_done}, exp_out);
            else passed++;
        end
        capture_frame(got, seen);
        total++;
        if (!seen || got !== {7'h7F, 7'h7F, 7'h7F, 7'h30, 7'h19} || pending !== 1'b0)
            $display("FAIL overwrite_digits seen=%b got=%h exp=%h pend=%b", seen, got,
                     {7'h7F, 7'h7F, 7'h7F, 7'h30, 7'h19}, pending);
        else passed++;
    endtask

    task automatic test_boundary_load();
        logic [34:0] got;
        bit          seen;
        bit          rose = 1'b0;
        for (int i = 0; i < FRAME && (m_cnt % FRAME) != FRAME - 1; i++) cycle(1'b0, 20'h0, 1'b0);
        cycle(1'b1, 20'h10203, 1'b0);
        if (pending !== 1'b0) rose = 1'b1;
        total++;
        if (frame_done !== 1'b1) $display("FAIL boundary_frame_done got=%b exp=1", frame_done);
        else passed++;
        for (int i = 0; i < FRAME; i++) begin
            cycle(1'b0, 20'h0, 1'b0);
            if (pending !== 1'b0) rose = 1'b1;
            for (int k = 0; k < 5; k++)
                if (an === ~(5'b00001 << k)) got[7*k +: 7] = seg;
        end
        seen = 1'b1;
        total++;
        if (rose || got !== {7'h79, 7'h40, 7'h24, 7'h40, 7'h30})
            $display("FAIL boundary_load pend_rose=%b got=%h exp=%h", rose, got,
                     {7'h79, 7'h40, 7'h24, 7'h40, 7'h30});
        else passed++;
    endtask

    task automatic test_reset_mid_scan();
        cycle(1'b1, 20'h98765, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 20'h0, 1'b0);
        cycle(1'b0, 20'h0, 1'b1);
        total++;
        if (an !== 5'b11111 || seg !== 7'h7F || pending !== 1'b0)
            $display("FAIL reset_mid an=%b seg=%h pend=%b exp an=11111 seg=7f pend=0", an, seg, pending);
        else passed++;
        for (int i = 0; i < 2 * FRAME + 2; i++) begin
            cycle(1'b0, 20'h0, 1'b0);
            total++;
            if ({an, seg, pending, frame_done} !== exp_out)
                $display("FAIL reset_mid_scan cyc=%0d got=%h exp=%h", i, {an, seg, pending, frame_done}, exp_out);
            else passed++;
        end
    endtask

    task automatic test_hex_codes();
        logic [34:0] got;
        bit          seen;
        cycle(1'b1, 20'h0B0C5, 1'b0);
        capture_frame(got, seen);
        total++;
        if (!seen || got !== {7'h7F, 7'h7F, 7'h40, 7'h7F, 7'h12})
            $display("FAIL hex_codes seen=%b got=%h exp=%h", seen, got, {7'h7F, 7'h7F, 7'h40, 7'h7F, 7'h12});
        else passed++;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3 * FRAME; i++) begin
            if (i < 4) cycle(1'b1, rand_value(), 1'b0);
            else cycle(1'b0, 20'h0, 1'b0);
            total++;
            if ({an, seg, pending, frame_done} !== exp_out)
                $display("FAIL back_to_back cyc=%0d got=%h exp=%h", i, {an, seg, pending, frame_done}, exp_out);
            else passed++;
        end
    endtask

    task automatic test_random();
        logic [19:0] v;
        for (int i = 0; i < 600; i++) begin
            v = rand_value();
            if (($urandom_range(0, 4) == 0) && (v[19:16] inside {[4'hA:4'hE]})) v[19:16] = 4'h0;
            cycle($urandom_range(0, 5) == 0, v, $urandom_range(0, 199) == 0);
            total++;
            if ({an, seg, pending, frame_done} !== exp_out)
                $display("FAIL random cyc=%0d got=%h exp=%h", i, {an, seg, pending, frame_done}, exp_out);
            else passed++;
        end
    endtask

    initial begin
        reset   = 1'b1;
        load    = 1'b0;
        value   = 20'h0;
        m_cnt   = 0;
        m_act   = 20'h0;
        m_buf   = 20'h0;
        m_pend  = 1'b0;
        exp_out = '0;
        test_reset();
        test_idle_scan();
        test_load_mid_frame();
        test_overwrite();
        test_boundary_load();
        test_reset_mid_scan();
        test_hex_codes();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
